// File: rtl/spi_adc_slave.sv
// SPI responder emulating a two-channel ADC: receives an 8-bit command and
// returns the selected channel sample MSB-first on miso. All SPI inputs are oversampled on clk_i.
module spi_adc_slave #(
  parameter int DataWidth = 12,
  parameter int CmdWidth  = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cs_i,
  input  logic                 dclk_i,
  input  logic                 mosi_i,
  input  logic [DataWidth-1:0] ch0_data_i,
  input  logic [DataWidth-1:0] ch1_data_i,
  output logic                 miso_o,
  output logic                 miso_oe_o,
  output logic [CmdWidth-1:0]  cmd_o,
  output logic                 cmd_vld_o,
  output logic                 done_o,
  output logic                 abort_o
);

  localparam int FrameBits = CmdWidth + DataWidth;
  localparam int CntW      = $clog2(FrameBits + 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, TAIL} state_t;

  state_t               state;
  logic [2:0]           cs_q;
  logic [2:0]           dclk_q;
  logic [1:0]           mosi_q;
  logic [CntW-1:0]      cnt;
  logic [CmdWidth-1:0]  cmd_sh;
  logic [DataWidth-1:0] tx;
  logic                 cs_fall, cs_rise, dclk_rise, dclk_fall;
  logic [CmdWidth-1:0]  next_cmd;

  // Stages [1:0] synchronize; stage [2] is the previous synchronized value for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cs_q   <= '1;
      dclk_q <= '0;
      mosi_q <= '0;
    end else begin
      cs_q   <= {cs_q[1:0], cs_i};
      dclk_q <= {dclk_q[1:0], dclk_i};
      mosi_q <= {mosi_q[0], mosi_i};
    end
  end

  always_comb begin
    cs_fall   = cs_q[2] & ~cs_q[1];
    cs_rise   = ~cs_q[2] & cs_q[1];
    dclk_rise = ~dclk_q[2] & dclk_q[1];
    dclk_fall = dclk_q[2] & ~dclk_q[1];
    next_cmd  = {cmd_sh[CmdWidth-2:0], mosi_q[1]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_sh    <= '0;
      tx        <= '0;
      miso_o    <= 1'b0;
      miso_oe_o <= 1'b0;
      cmd_o     <= '0;
      cmd_vld_o <= 1'b0;
      done_o    <= 1'b0;
      abort_o   <= 1'b0;
    end else begin
      cmd_vld_o <= 1'b0;
      done_o    <= 1'b0;
      abort_o   <= 1'b0;
      case (state)
        IDLE: begin
          miso_o    <= 1'b0;
          miso_oe_o <= 1'b0;
          if (cs_fall) begin
            state     <= CMD;
            cnt       <= '0;
            cmd_sh    <= '0;
            miso_oe_o <= 1'b1;
          end
        end
        CMD: begin
          // cs rise takes priority over any simultaneous dclk edge
          if (cs_rise) begin
            abort_o   <= 1'b1;
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            state     <= IDLE;
          end else if (dclk_rise) begin
            cmd_sh <= next_cmd;
            cnt    <= cnt + 1'b1;
            if (cnt == CntW'(CmdWidth - 1)) begin
              cmd_o <= next_cmd;
              if (next_cmd[CmdWidth-1]) begin
                cmd_vld_o <= 1'b1;
                tx        <= next_cmd[CmdWidth-2] ? ch1_data_i : ch0_data_i;
                state     <= DATA;
              end else begin
                abort_o <= 1'b1;
                miso_o  <= 1'b0;
                state   <= TAIL;
              end
            end
          end
        end
        DATA: begin
          if (cs_rise) begin
            abort_o   <= 1'b1;
            miso_o    <= 1'b0;
            miso_oe_o <= 1'b0;
            state     <= IDLE;
          end else if (dclk_fall) begin
            miso_o <= tx[DataWidth-1];
            tx     <= {tx[DataWidth-2:0], 1'b0};
          end else if (dclk_rise) begin
            if (cnt == CntW'(FrameBits - 1)) begin
              cnt    <= CntW'(FrameBits);
              done_o <= 1'b1;
              miso_o <= 1'b0;
              state  <= TAIL;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        TAIL: begin
          miso_o <= 1'b0;
          if (cs_rise) begin
            miso_oe_o <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_adc_slave.sv
// Directed bench for spi_adc_slave: drives SPI frames as a master and checks read-back
// words against a scoreboard plus pulse counts of cmd_vld/done/abort.
module tb_spi_adc_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs = 1'b1;
  logic        dclk = 1'b0;
  logic        mosi = 1'b0;
  logic [11:0] ch0 = 12'hA5C;
  logic [11:0] ch1 = 12'h3F0;
  logic        miso, miso_oe, cmd_vld, done, abort;
  logic [7:0]  cmd;

  int n_assert = 0;
  int n_fail   = 0;
  int vld_n = 0, vld_hi = 0, done_n = 0, done_hi = 0, abort_n = 0, abort_hi = 0;
  logic vld_p = 1'b0, done_p = 1'b0, abort_p = 1'b0;
  logic [11:0] sb[$];

  spi_adc_slave #(.DataWidth(12), .CmdWidth(8)) dut (
    .clk_i(clk), .rst_i(rst), .cs_i(cs), .dclk_i(dclk), .mosi_i(mosi),
    .ch0_data_i(ch0), .ch1_data_i(ch1),
    .miso_o(miso), .miso_oe_o(miso_oe), .cmd_o(cmd),
    .cmd_vld_o(cmd_vld), .done_o(done), .abort_o(abort)
  );

  always #5 clk = ~clk;

  // Pulse monitor: number of pulses and number of high cycles (equal when every pulse is 1 cycle)
  always @(negedge clk) begin
    if (cmd_vld) vld_hi++;
    if (cmd_vld && !vld_p) vld_n++;
    if (done) done_hi++;
    if (done && !done_p) done_n++;
    if (abort) abort_hi++;
    if (abort && !abort_p) abort_n++;
    vld_p = cmd_vld; done_p = done; abort_p = abort;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs = 1'b0;
    wait_clk(6);
    check("oe_active", {31'b0, miso_oe}, 32'd1);
  endtask

  task automatic cs_high();
    cs = 1'b1;
    wait_clk(8);
    check("oe_idle", {31'b0, miso_oe}, 32'd0);
  endtask

  task automatic spi_bit(input logic b, output logic m);
    mosi = b;
    wait_clk(6);
    dclk = 1'b1;
    m = miso;
    wait_clk(6);
    dclk = 1'b0;
  endtask

  // Clocks nbits dclk periods with cmd in the first 8; optionally scrambles channel inputs mid-frame.
  task automatic frame(input logic [7:0] c, input int nbits, input logic scramble,
                       output logic [31:0] rd);
    logic m;
    logic [11:0] s0, s1;
    s0 = ch0; s1 = ch1;
    rd = '0;
    cs_low();
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < 8) ? c[7 - i] : 1'b0, m);
      rd = {rd[30:0], m};
      if (scramble && i == 9) begin
        ch0 = 12'h123; ch1 = 12'h456;
      end
    end
    cs_high();
    ch0 = s0; ch1 = s1;
  endtask

  function automatic logic [11:0] model(input logic [7:0] c, input logic [11:0] d0,
                                        input logic [11:0] d1);
    if (!c[7]) return 12'h000;
    return c[6] ? d1 : d0;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [11:0] exp;
    int v0, d0, a0;

    wait_clk(4);
    check("rst_miso", {31'b0, miso}, 0);
    check("rst_oe", {31'b0, miso_oe}, 0);
    check("rst_cmd", {24'b0, cmd}, 0);
    check("rst_pulses", {29'b0, cmd_vld, done, abort}, 0);
    rst = 1'b0;
    wait_clk(4);

    // 1: channel 0, channel inputs change after command completes
    v0 = vld_n; d0 = done_n; a0 = abort_n;
    sb.push_back(model(8'h97, ch0, ch1));
    frame(8'h97, 20, 1'b1, rd);
    exp = sb.pop_front();
    check("t1_data", {20'b0, rd[11:0]}, {20'b0, exp});
    check("t1_cmd", {24'b0, cmd}, 32'h97);
    check("t1_vld", vld_n - v0, 1);
    check("t1_done", done_n - d0, 1);
    check("t1_abort", abort_n - a0, 0);

    // 2: channel 1
    v0 = vld_n; d0 = done_n; a0 = abort_n;
    sb.push_back(model(8'hD7, ch0, ch1));
    frame(8'hD7, 20, 1'b0, rd);
    exp = sb.pop_front();
    check("t2_data", {20'b0, rd[11:0]}, {20'b0, exp});
    check("t2_cmd", {24'b0, cmd}, 32'hD7);
    check("t2_done", done_n - d0, 1);
    check("t2_abort", abort_n - a0, 0);

    // 3: early cs rise after 10 dclk, then a clean frame
    v0 = vld_n; d0 = done_n; a0 = abort_n;
    frame(8'h97, 10, 1'b0, rd);
    check("t3_abort", abort_n - a0, 1);
    check("t3_done", done_n - d0, 0);
    check("t3_vld", vld_n - v0, 1);
    check("t3_state", {30'b0, dut.state}, 0);
    sb.push_back(model(8'hD7, ch0, ch1));
    frame(8'hD7, 20, 1'b0, rd);
    exp = sb.pop_front();
    check("t3_next_data", {20'b0, rd[11:0]}, {20'b0, exp});

    // 4: missing start bit
    v0 = vld_n; d0 = done_n; a0 = abort_n;
    sb.push_back(model(8'h17, ch0, ch1));
    frame(8'h17, 20, 1'b0, rd);
    exp = sb.pop_front();
    check("t4_data", {20'b0, rd[11:0]}, {20'b0, exp});
    check("t4_abort", abort_n - a0, 1);
    check("t4_vld", vld_n - v0, 0);
    check("t4_done", done_n - d0, 0);
    check("t4_cmd", {24'b0, cmd}, 32'h17);

    // 5: overlong frame, trailing bits read as zero
    d0 = done_n; a0 = abort_n;
    sb.push_back(model(8'h97, ch0, ch1));
    frame(8'h97, 24, 1'b0, rd);
    exp = sb.pop_front();
    check("t5_data", {20'b0, rd[15:4]}, {20'b0, exp});
    check("t5_tail", {28'b0, rd[3:0]}, 0);
    check("t5_done", done_n - d0, 1);
    check("t5_abort", abort_n - a0, 0);

    // 6: reset mid-DATA
    d0 = done_n;
    begin
      logic m;
      cs_low();
      for (int i = 0; i < 14; i++) spi_bit((i < 8) ? rd[0] | (i == 0 || i == 3 || i >= 5) : 1'b0, m);
    end
    rst = 1'b1;
    #1;
    check("t6_miso", {31'b0, miso}, 0);
    check("t6_oe", {31'b0, miso_oe}, 0);
    check("t6_cmd", {24'b0, cmd}, 0);
    check("t6_pulses", {29'b0, cmd_vld, done, abort}, 0);
    cs = 1'b1; dclk = 1'b0; mosi = 1'b0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(5);
    check("t6_no_done", done_n - d0, 0);
    sb.push_back(model(8'h97, ch0, ch1));
    frame(8'h97, 20, 1'b0, rd);
    exp = sb.pop_front();
    check("t6_data", {20'b0, rd[11:0]}, {20'b0, exp});
    check("t6_cmd_after", {24'b0, cmd}, 32'h97);

    check("pulse_width_vld", vld_hi, vld_n);
    check("pulse_width_done", done_hi, done_n);
    check("pulse_width_abort", abort_hi, abort_n);
    check("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
